// File: rtl/arb_mux_nx1.sv
// arb_mux_nx1: N-to-1 registered arbitrating mux with valid/ready handshakes
// Fixed-priority (MODE 0) or round-robin (MODE 1) arbitration into a one-entry output register.
module arb_mux_nx1 #(
    parameter int WIDTH = 16,
    parameter int N = 4,
    parameter int MODE = 0,
    localparam int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [SW-1:0]    out_sel,
    input  logic             out_ready
);
    logic [SW-1:0] ptr;
    logic [SW-1:0] g;
    logic any;
    logic load;
    int idx;

    // Search runs from the lowest-priority position down so the last hit is the winner
    always_comb begin
        g = '0;
        any = 1'b0;
        idx = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = MODE == 1 ? (int'(ptr) + k) % N : k;
            if (in_valid[idx]) begin
                g = SW'(idx);
                any = 1'b1;
            end
        end
    end

    assign load = rst_n & any & (~out_valid | out_ready);
    assign in_ready = load ? N'(1) << g : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_valid <= 1'b0;
            out_sel <= '0;
            ptr <= '0;
        end else if (load) begin
            out_data <= in_data[g*WIDTH +: WIDTH];
            out_valid <= 1'b1;
            out_sel <= g;
            if (MODE == 1) ptr <= g == SW'(N - 1) ? '0 : g + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_arb_mux_nx1.sv
// tb_arb_mux_nx1: checks fixed-priority, round-robin and N=3 instances against a spec-level model
module tb_arb_mux_nx1;
    logic clk;
    logic rst_n;
    logic [3:0] iv [3];
    logic [63:0] idata [3];
    logic [3:0] ir [3];
    logic [2:0] ir2;
    logic [15:0] od [3];
    logic ov [3];
    logic [1:0] os [3];
    logic ordy [3];
    int n_cmp, n_bad;
    const int nn [3] = '{4, 4, 3};
    const int mode_of [3] = '{0, 1, 1};
    const logic [15:0] words [4] = '{16'hABCD, 16'h0088, 16'h1234, 16'hFFFF};
    logic mv [3];
    logic [15:0] mdat [3];
    int ms [3], mp [3];

    assign ir[2] = {1'b0, ir2};

    arb_mux_nx1 #(.WIDTH(16), .N(4), .MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_data(idata[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_sel(os[0]), .out_ready(ordy[0]));
    arb_mux_nx1 #(.WIDTH(16), .N(4), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(idata[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_sel(os[1]), .out_ready(ordy[1]));
    arb_mux_nx1 #(.WIDTH(16), .N(3), .MODE(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_data(idata[2][47:0]), .in_valid(iv[2][2:0]), .in_ready(ir2),
        .out_data(od[2]), .out_valid(ov[2]), .out_sel(os[2]), .out_ready(ordy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int grant(input logic [3:0] v, input int p, input int n, input int m);
        for (int k = 0; k < n; k++)
            if (v[m == 1 ? (p + k) % n : k]) return m == 1 ? (p + k) % n : k;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int i);
        int g;
        g = grant(iv[i], mp[i], nn[i], mode_of[i]);
        return (rst_n && (!mv[i] || ordy[i]) && g >= 0) ? 4'(1 << g) : 4'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0;
            mdat[i] = '0;
            ms[i] = 0;
            mp[i] = 0;
        end
    endtask

    task automatic tick();
        int g;
        @(posedge clk);
        if (rst_n)
            for (int i = 0; i < 3; i++) begin
                g = grant(iv[i], mp[i], nn[i], mode_of[i]);
                if ((!mv[i] || ordy[i]) && g >= 0) begin
                    mv[i] = 1'b1;
                    mdat[i] = idata[i][g*16 +: 16];
                    ms[i] = g;
                    if (mode_of[i] == 1) mp[i] = (g + 1) % nn[i];
                end else if (ordy[i]) begin
                    mv[i] = 1'b0;
                end
            end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            iv[i] = i == 2 ? 4'b0111 : 4'b1111;
            idata[i] = {words[3], words[2], words[1], words[0]};
            ordy[i] = 1'b1;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            n_cmp += 4;
            if (ov[i] !== 1'b0) begin n_bad++; $display("FAIL reset_valid inst%0d: got %b expected 0", i, ov[i]); end
            if (od[i] !== 16'h0) begin n_bad++; $display("FAIL reset_data inst%0d: got %h expected 0000", i, od[i]); end
            if (os[i] !== 2'd0) begin n_bad++; $display("FAIL reset_sel inst%0d: got %0d expected 0", i, os[i]); end
            if (ir[i] !== 4'b0) begin n_bad++; $display("FAIL reset_ready inst%0d: got %b expected 0000", i, ir[i]); end
        end
        for (int i = 0; i < 3; i++) iv[i] = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ov[i] !== 1'b0) begin n_bad++; $display("FAIL idle_valid inst%0d: got %b expected 0", i, ov[i]); end
            end
        end
    endtask

    task automatic test_fixed_priority();
        iv[0] = 4'b1110;
        ordy[0] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (ir[0] !== 4'b0010) begin n_bad++; $display("FAIL fp_ready: got %b expected 0010", ir[0]); end
            tick();
            n_cmp += 3;
            if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL fp_valid: got %b expected 1", ov[0]); end
            if (od[0] !== 16'h0088) begin n_bad++; $display("FAIL fp_data: got %h expected 0088", od[0]); end
            if (os[0] !== 2'd1) begin n_bad++; $display("FAIL fp_sel: got %0d expected 1", os[0]); end
        end
        iv[0] = 4'b0;
    endtask

    task automatic test_round_robin();
        iv[1] = 4'b1111;
        ordy[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ir[1] !== 4'(1 << (k % 4))) begin n_bad++; $display("FAIL rr_ready cycle%0d: got %b expected %b", k, ir[1], 4'(1 << (k % 4))); end
            tick();
            n_cmp += 2;
            if (os[1] !== 2'(k % 4)) begin n_bad++; $display("FAIL rr_sel cycle%0d: got %0d expected %0d", k, os[1], k % 4); end
            if (od[1] !== words[k % 4]) begin n_bad++; $display("FAIL rr_data cycle%0d: got %h expected %h", k, od[1], words[k % 4]); end
        end
    endtask

    task automatic test_backpressure();
        iv[1] = 4'b0001;
        ordy[1] = 1'b1;
        tick();
        n_cmp++;
        if (od[1] !== 16'hABCD) begin n_bad++; $display("FAIL bp_load: got %h expected abcd", od[1]); end
        iv[1] = 4'b1111;
        ordy[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (ir[1] !== 4'b0) begin n_bad++; $display("FAIL bp_ready: got %b expected 0000", ir[1]); end
            tick();
            n_cmp += 3;
            if (od[1] !== 16'hABCD) begin n_bad++; $display("FAIL bp_data: got %h expected abcd", od[1]); end
            if (os[1] !== 2'd0) begin n_bad++; $display("FAIL bp_sel: got %0d expected 0", os[1]); end
            if (ov[1] !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b expected 1", ov[1]); end
        end
        ordy[1] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ir[1] !== 4'b0010) begin n_bad++; $display("FAIL bp_release_ready: got %b expected 0010", ir[1]); end
        tick();
        n_cmp += 2;
        if (od[1] !== 16'h0088) begin n_bad++; $display("FAIL bp_release_data: got %h expected 0088", od[1]); end
        if (os[1] !== 2'd1) begin n_bad++; $display("FAIL bp_release_sel: got %0d expected 1", os[1]); end
    endtask

    task automatic test_wrap_n3();
        iv[2] = 4'b0100;
        ordy[2] = 1'b1;
        tick();
        n_cmp += 2;
        if (os[2] !== 2'd2) begin n_bad++; $display("FAIL wrap_first_sel: got %0d expected 2", os[2]); end
        if (od[2] !== 16'h1234) begin n_bad++; $display("FAIL wrap_first_data: got %h expected 1234", od[2]); end
        iv[2] = 4'b0111;
        @(negedge clk);
        n_cmp++;
        if (ir[2] !== 4'b0001) begin n_bad++; $display("FAIL wrap_ready: got %b expected 0001", ir[2]); end
        tick();
        n_cmp++;
        if (os[2] !== 2'd0) begin n_bad++; $display("FAIL wrap_sel: got %0d expected 0", os[2]); end
        iv[2] = 4'b0;
    endtask

    task automatic test_back_to_back_and_reset();
        idata[1][31:16] = 16'h5A5A;
        iv[1] = 4'b0010;
        ordy[1] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ir[1] !== 4'b0010) begin n_bad++; $display("FAIL b2b_ready: got %b expected 0010", ir[1]); end
        tick();
        n_cmp += 3;
        if (ov[1] !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %b expected 1", ov[1]); end
        if (od[1] !== 16'h5A5A) begin n_bad++; $display("FAIL b2b_data: got %h expected 5a5a", od[1]); end
        if (os[1] !== 2'd1) begin n_bad++; $display("FAIL b2b_sel: got %0d expected 1", os[1]); end
        iv[1] = 4'b1111;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp += 3;
        if (ov[1] !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b expected 0", ov[1]); end
        if (od[1] !== 16'h0) begin n_bad++; $display("FAIL midreset_data: got %h expected 0000", od[1]); end
        if (ir[1] !== 4'b0) begin n_bad++; $display("FAIL midreset_ready: got %b expected 0000", ir[1]); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ir[1] !== 4'b0001) begin n_bad++; $display("FAIL postreset_ready: got %b expected 0001", ir[1]); end
        tick();
        n_cmp += 2;
        if (os[1] !== 2'd0) begin n_bad++; $display("FAIL postreset_sel: got %0d expected 0", os[1]); end
        if (od[1] !== 16'hABCD) begin n_bad++; $display("FAIL postreset_data: got %h expected abcd", od[1]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i] = 4'($urandom) & (i == 2 ? 4'b0111 : 4'b1111);
                idata[i] = {$urandom, $urandom};
                ordy[i] = $urandom_range(0, 3) != 0;
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ir[i] !== exp_ready(i)) begin n_bad++; $display("FAIL rand_ready inst%0d cycle%0d: got %b expected %b", i, c, ir[i], exp_ready(i)); end
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_cmp += 3;
                if (ov[i] !== mv[i]) begin n_bad++; $display("FAIL rand_valid inst%0d cycle%0d: got %b expected %b", i, c, ov[i], mv[i]); end
                if (od[i] !== mdat[i]) begin n_bad++; $display("FAIL rand_data inst%0d cycle%0d: got %h expected %h", i, c, od[i], mdat[i]); end
                if (os[i] !== 2'(ms[i])) begin n_bad++; $display("FAIL rand_sel inst%0d cycle%0d: got %0d expected %0d", i, c, os[i], ms[i]); end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_wrap_n3();
        test_back_to_back_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
